uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_cfg_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_rx_cfg.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity mode constants, receiver FSM encoding and a clog2 helper
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line, pop request and receive-FIFO status of uart_rx_cfg
interface uart_rx_cfg_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);

   localparam int CW = uart_pkg::clog2(FIFO_DEPTH) + 1;

   logic                 Rx;
   logic                 NxT;
   logic [DATA_BITS-1:0] O_DATA;
   logic                 O_PERR;
   logic                 O_FERR;
   logic                 O_OVR;
   logic                 NrD;
   logic                 clk_Rx;
   logic                 Rx_FULL;
   logic                 Rx_EMPTY;
   logic [CW-1:0]        Rx_COUNT;

   modport slave (
      input  Rx, NxT,
      output O_DATA, O_PERR, O_FERR, O_OVR, NrD, clk_Rx, Rx_FULL, Rx_EMPTY, Rx_COUNT
   );

   modport master (
      output Rx, NxT,
      input  O_DATA, O_PERR, O_FERR, O_OVR, NrD, clk_Rx, Rx_FULL, Rx_EMPTY, Rx_COUNT
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through receive FIFO with sticky overrun flag
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int WIDTH = 10,
   parameter  int DEPTH = 16,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_ovr,
   output logic [AW:0]      o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_ovr;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW + 1)'(DEPTH));
   assign w_pop   = i_rd & ~o_empty;
   // a simultaneous pop frees the slot, so a write into a full FIFO still lands
   assign w_push  = i_wr & (~o_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovr    <= 1'b0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push);
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_count  <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
         r_ovr    <= w_pop ? 1'b0 : (r_ovr | (i_wr & o_full));
      end
   end

   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_ovr   = r_ovr;
   assign o_count = r_count;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with mid-bit sampling feeding a FWFT FIFO
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int BAUDS      = 104,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input logic          clk,
   input logic          rst,
   uart_rx_cfg_if.slave io_rx
);

   localparam logic [15:0] HALF      = 16'(BAUDS / 2);
   localparam logic [15:0] RELOAD    = 16'(BAUDS - 1);
   localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic        LAST_STOP = 1'(STOP_BITS - 1);
   localparam bit          PAR_ON    = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
   localparam int          W         = DATA_BITS + 2;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_rx_s1;
   logic                 r_rx_s2;
   logic                 r_nxt_s1;
   logic                 r_nxt_s2;
   logic                 r_nxt_d;
   logic [1:0]           r_vld;
   logic                 r_armed;
   logic [15:0]          r_cnt;
   logic [3:0]           r_bit_idx;
   logic                 r_stop_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_wr;
   logic [W-1:0]         r_wr_word;
   logic                 w_fall;
   logic                 w_tick;
   logic                 w_sample;
   logic                 w_last_stop;
   logic                 w_ferr_now;
   logic                 w_perr_now;
   logic                 w_perr_tag;
   logic [W-1:0]         w_head;

   // r_armed only holds a real high sample, so the synchroniser's reset value
   // can never fake a falling edge when the line is low as reset releases
   assign w_fall     = r_armed & ~r_rx_s2;
   assign w_tick     = (r_cnt == '0);
   assign w_ferr_now = r_ferr | ~r_rx_s2;
   assign w_perr_now = ^{r_shift, r_rx_s2} ^ (PARITY == PAR_ODD);
   assign w_perr_tag = (PARITY == PAR_NONE) ? 1'b0 : r_perr;

   always_comb begin
      w_state_nxt = r_state;
      w_sample    = 1'b0;
      w_last_stop = 1'b0;
      case (r_state)
         S_IDLE: w_state_nxt = w_fall ? S_START : S_IDLE;
         S_START: if (w_tick) begin
            w_sample    = 1'b1;
            w_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
         end
         S_DATA: if (w_tick) begin
            w_sample = 1'b1;
            if (r_bit_idx == LAST_BIT) w_state_nxt = PAR_ON ? S_PAR : S_STOP;
         end
         S_PAR: if (w_tick) begin
            w_sample    = 1'b1;
            w_state_nxt = S_STOP;
         end
         S_STOP: if (w_tick) begin
            w_sample    = 1'b1;
            w_last_stop = (r_stop_idx == LAST_STOP);
            if (w_last_stop) w_state_nxt = w_ferr_now ? S_WAIT_IDLE : S_IDLE;
         end
         S_WAIT_IDLE: w_state_nxt = r_rx_s2 ? S_IDLE : S_WAIT_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_nxt_s1   <= 1'b1;
         r_nxt_s2   <= 1'b1;
         r_nxt_d    <= 1'b1;
         r_vld      <= '0;
         r_armed    <= 1'b0;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_wr       <= 1'b0;
         r_wr_word  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rx_s1    <= io_rx.Rx;
         r_rx_s2    <= r_rx_s1;
         r_nxt_s1   <= io_rx.NxT;
         r_nxt_s2   <= r_nxt_s1;
         r_nxt_d    <= r_nxt_s2;
         r_vld      <= {r_vld[0], 1'b1};
         r_armed    <= r_vld[1] & r_rx_s2;
         r_cnt      <= (r_state == S_IDLE) ? (w_fall ? HALF : '0) : (w_tick ? RELOAD : r_cnt - 16'd1);
         r_bit_idx  <= (r_state == S_IDLE) ? '0 : r_bit_idx + 4'(w_sample && r_state == S_DATA);
         r_stop_idx <= (r_state == S_IDLE) ? 1'b0 : r_stop_idx ^ (w_sample && r_state == S_STOP);
         r_ferr     <= (r_state == S_IDLE) ? 1'b0 : (w_sample && r_state == S_STOP) ? w_ferr_now : r_ferr;
         r_perr     <= (r_state == S_IDLE) ? 1'b0 : (w_sample && r_state == S_PAR) ? w_perr_now : r_perr;
         if (w_sample && r_state == S_DATA) r_shift <= {r_rx_s2, r_shift[DATA_BITS-1:1]};
         r_wr       <= w_last_stop;
         if (w_last_stop) r_wr_word <= {w_perr_tag, w_ferr_now, r_shift};
      end
   end

   uart_rx_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (r_wr),
      .i_wdata (r_wr_word),
      .i_rd    (r_nxt_s2 & ~r_nxt_d),
      .o_rdata (w_head),
      .o_full  (io_rx.Rx_FULL),
      .o_empty (io_rx.Rx_EMPTY),
      .o_ovr   (io_rx.O_OVR),
      .o_count (io_rx.Rx_COUNT)
   );

   assign io_rx.O_DATA = w_head[DATA_BITS-1:0];
   assign io_rx.O_FERR = w_head[DATA_BITS];
   assign io_rx.O_PERR = w_head[DATA_BITS+1];
   assign io_rx.NrD    = r_wr;
   assign io_rx.clk_Rx = w_sample;

endmodule
